// File: rtl/cellrv32_board_led_ctrl.sv
// -----------------------------------------------------------------------------
// cellrv32_board_led_ctrl
//
// Board-level output stage between the processor GPIO outputs and the LEDs.
// Each channel runs in one of four modes: pass-through, blink, PWM-dimmed or
// forced off. Modes and PWM duties are set through a one-cycle write port that
// answers every write with either an ack or an error pulse.
//
// Ports
//   clk_i       clock, rising edge
//   rst_i       synchronous reset, active-high
//   gpio_i      [NUM_CH]   processor GPIO output bits
//   cfg_we_i    config write strobe (one cycle)
//   cfg_ch_i    [CH_W]     channel index of the write
//   cfg_mode_i  [2]        00 PASS, 01 BLINK, 10 PWM, 11 OFF
//   cfg_duty_i  [PWM_BITS] PWM duty for the channel (goes to the shadow copy)
//   cfg_ack_o   pulse one cycle after an accepted write
//   cfg_err_o   pulse one cycle after a write to a non-existent channel
//   led_o       [NUM_CH]   registered LED drive, active-high
//   pwm_wrap_o  pulse in the cycle after the PWM counter held its maximum
// -----------------------------------------------------------------------------
module cellrv32_board_led_ctrl #(
  parameter int NUM_CH          = 18,
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BLINK_HZ        = 2,
  parameter int PWM_BITS        = 8
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic [NUM_CH-1:0]                           gpio_i,
  input  logic                                        cfg_we_i,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch_i,
  input  logic [1:0]                                  cfg_mode_i,
  input  logic [PWM_BITS-1:0]                         cfg_duty_i,
  output logic                                        cfg_ack_o,
  output logic                                        cfg_err_o,
  output logic [NUM_CH-1:0]                           led_o,
  output logic                                        pwm_wrap_o
);

  localparam int HALF_RAW = CLOCK_FREQUENCY / (2 * BLINK_HZ);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int PRE_W    = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(HALF - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_BLINK = 2'b01,
    MODE_PWM   = 2'b10,
    MODE_OFF   = 2'b11
  } mode_e;

  mode_e               mode_q     [NUM_CH];
  logic [PWM_BITS-1:0] duty_act_q [NUM_CH];
  logic [PWM_BITS-1:0] duty_shd_q [NUM_CH];

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PRE_W-1:0]    pre_q;
  logic                phase_q;
  logic                ch_ok;
  logic                pwm_last;
  logic [NUM_CH-1:0]   led_p0;

  // Per-channel output decision from mode, GPIO bit, blink phase and PWM compare.
  function automatic logic led_bit(input mode_e m, input logic g, input logic ph,
                                   input logic pwm_on);
    logic b;
    case (m)
      MODE_PASS:  b = g;
      MODE_BLINK: b = g & ph;
      MODE_PWM:   b = g & pwm_on;
      default:    b = 1'b0;
    endcase
    return b;
  endfunction

  assign ch_ok    = (int'(cfg_ch_i) < NUM_CH);
  assign pwm_last = (pwm_cnt_q == CNT_MAX);

  // Stage p0: combinational LED value from current state, registered into led_o.
  always_comb begin
    led_p0 = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      led_p0[i] = led_bit(mode_q[i], gpio_i[i], phase_q, (pwm_cnt_q < duty_act_q[i]));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwm_cnt_q  <= '0;
      pre_q      <= '0;
      phase_q    <= 1'b0;
      led_o      <= '0;
      cfg_ack_o  <= 1'b0;
      cfg_err_o  <= 1'b0;
      pwm_wrap_o <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i]     <= MODE_PASS;
        duty_act_q[i] <= '1;
        duty_shd_q[i] <= '1;
      end
    end else begin
      pwm_cnt_q  <= pwm_cnt_q + 1'b1;
      pwm_wrap_o <= pwm_last;

      if (pre_q == PRE_LAST) begin
        pre_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        pre_q <= pre_q + 1'b1;
      end

      cfg_ack_o <= cfg_we_i & ch_ok;
      cfg_err_o <= cfg_we_i & ~ch_ok;
      led_o     <= led_p0;

      for (int i = 0; i < NUM_CH; i++) begin
        // Active duty samples the shadow as it was before this edge, so a
        // write landing on the wrap edge waits for the following wrap.
        if (pwm_last) begin
          duty_act_q[i] <= duty_shd_q[i];
        end
        if (cfg_we_i && ch_ok && (int'(cfg_ch_i) == i)) begin
          mode_q[i]     <= mode_e'(cfg_mode_i);
          duty_shd_q[i] <= cfg_duty_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_cellrv32_board_led_ctrl.sv
module tb_cellrv32_board_led_ctrl;

  localparam int NCH = 18;

  logic            clk = 1'b0;
  logic            rst;
  logic [NCH-1:0]  gpio;
  logic            we;
  logic [4:0]      ch;
  logic [1:0]      md;
  logic [7:0]      duty;
  logic            cfg_ack, cfg_err, pwm_wrap;
  logic [NCH-1:0]  led;

  cellrv32_board_led_ctrl #(
    .NUM_CH(NCH), .CLOCK_FREQUENCY(1000), .BLINK_HZ(50), .PWM_BITS(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .gpio_i(gpio), .cfg_we_i(we), .cfg_ch_i(ch),
    .cfg_mode_i(md), .cfg_duty_i(duty), .cfg_ack_o(cfg_ack), .cfg_err_o(cfg_err),
    .led_o(led), .pwm_wrap_o(pwm_wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] led;
    logic           ack;
    logic           err;
    logic           wrap;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: cycle count since reset gives PWM count and blink phase.
  int m_mode[NCH];
  int m_shd[NCH];
  int m_act[NCH];
  int m_n;

  bit win_en = 0;
  bit win_started = 0;
  int hi;
  int periods[$];

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = 0;
      m_shd[i]  = 255;
      m_act[i]  = 255;
    end
    m_n = 0;
  endtask

  task automatic step(input logic r, input logic [NCH-1:0] g, input logic w,
                      input logic [4:0] c, input logic [1:0] m, input logic [7:0] d);
    obs_t e;
    int   cnt, ph, prev;
    @(negedge clk);
    // led currently visible reflects the previous edge, whose count was m_n-1.
    if (!r && m_n >= 1 && win_en) begin
      prev = (m_n - 1) % 256;
      if (prev == 0) begin
        win_started = 1;
        hi = 0;
      end
      if (win_started) begin
        hi += int'(led[3]);
        if (prev == 255) periods.push_back(hi);
      end
    end
    rst = r; gpio = g; we = w; ch = c; md = m; duty = d;
    e = '0;
    if (r) begin
      model_reset();
    end else begin
      cnt = m_n % 256;
      ph  = (m_n / 10) % 2;
      for (int i = 0; i < NCH; i++) begin
        case (m_mode[i])
          0:       e.led[i] = g[i];
          1:       e.led[i] = g[i] && (ph == 1);
          2:       e.led[i] = g[i] && (cnt < m_act[i]);
          default: e.led[i] = 1'b0;
        endcase
      end
      e.ack  = w && (int'(c) < NCH);
      e.err  = w && (int'(c) >= NCH);
      e.wrap = (cnt == 255);
      if (cnt == 255) begin
        for (int i = 0; i < NCH; i++) m_act[i] = m_shd[i];
      end
      if (e.ack) begin
        m_mode[int'(c)] = int'(m);
        m_shd[int'(c)]  = int'(d);
      end
      m_n++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [NCH-1:0] g);
    step(1'b0, g, 1'b0, 5'd0, 2'b00, 8'd0);
  endtask

  task automatic run_to(input int c);
    while ((m_n % 256) != c) idle(NCH'($urandom) | 18'h8);
  endtask

  task automatic check(input string name, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // Scoreboard monitor: one registered output sample per clock.
  obs_t mon_e, mon_got;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e   = exp_q.pop_front();
      mon_got = {led, cfg_ack, cfg_err, pwm_wrap};
      n_cmp++;
      if (mon_got !== mon_e) begin
        n_bad++;
        $display("FAIL outputs t=%0t got led=%h ack=%b err=%b wrap=%b required led=%h ack=%b err=%b wrap=%b",
                 $time, mon_got.led, mon_got.ack, mon_got.err, mon_got.wrap,
                 mon_e.led, mon_e.ack, mon_e.err, mon_e.wrap);
      end
    end
  end

  initial begin
    rst = 1'b1; gpio = '0; we = 1'b0; ch = '0; md = '0; duty = '0;
    model_reset();

    step(1'b1, '0, 1'b0, 5'd0, 2'b00, 8'd0);
    step(1'b1, '0, 1'b0, 5'd0, 2'b00, 8'd0);

    // Pass-through after reset
    repeat (4) idle(18'h2A5A5);

    // PWM duty 64 on ch3, then 192 written mid-period
    step(1'b0, NCH'($urandom) | 18'h8, 1'b1, 5'd3, 2'b10, 8'd64);
    win_en = 1; win_started = 0; periods.delete();
    run_to(0);
    run_to(100);
    step(1'b0, NCH'($urandom) | 18'h8, 1'b1, 5'd3, 2'b10, 8'd192);
    repeat (700) idle(NCH'($urandom) | 18'h8);
    win_en = 0;
    check("pwm_period_count", periods.size() >= 3 ? 1 : 0, 1);
    if (periods.size() >= 3) begin
      check("pwm_period0_high", periods[0], 64);
      check("pwm_period1_high", periods[1], 192);
      check("pwm_period2_high", periods[2], 192);
    end

    // Blink on ch0 with gpio[0] held high
    step(1'b0, NCH'($urandom) | 18'h1, 1'b1, 5'd0, 2'b01, 8'd0);
    repeat (60) idle(NCH'($urandom) | 18'h1);

    // Bad channel write must change nothing
    step(1'b0, 18'h3FFFF, 1'b1, 5'd20, 2'b11, 8'd0);
    repeat (3) idle(18'h3FFFF);

    // Randomised writes (valid and invalid, back-to-back), occasional reset
    repeat (3000) begin
      step(($urandom_range(0, 799) == 0) ? 1'b1 : 1'b0, NCH'($urandom),
           ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0, 5'($urandom_range(0, 31)),
           2'($urandom), 8'($urandom));
    end

    // Reset mid-PWM with a pending shadow duty
    step(1'b0, 18'h3FFFF, 1'b1, 5'd3, 2'b10, 8'd200);
    run_to(40);
    step(1'b0, 18'h3FFFF, 1'b1, 5'd3, 2'b10, 8'd10);
    repeat (5) idle(18'h3FFFF);
    step(1'b1, 18'h3FFFF, 1'b0, 5'd0, 2'b00, 8'd0);
    repeat (4) idle(18'h3FFFF);
    @(negedge clk);
    check("post_reset_pass", int'(led), 32'h3FFFF);

    // Drain the scoreboard with a bounded wait
    repeat (4) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) break;
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
